per_rx_buffer: RTL and testbench
================================

PER_RX_BUFFER -- requirements
Module: per_rx_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO capacity in words; power of two, at least 2.
REQ-003 SHALL have port clkPER, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstPER, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port inSend, input, 2, send request from the upstream CPU; asserted iff value is 2'b01.
REQ-006 SHALL have port inData, input, WIDTH, upstream data word; stable while inSend is asserted.
REQ-007 SHALL have port outAck, output, 2, acknowledge to upstream; values 2'b00 or 2'b01 only.
REQ-008 SHALL have port outValid, output, 1, a downstream word is available.
REQ-009 SHALL have port inReady, input, 1, downstream consumer accepts the word.
REQ-010 SHALL have port outWord, output, WIDTH, head-of-FIFO word.
REQ-011 SHALL have port outCount, output, log2(DEPTH)+1, current FIFO occupancy.
REQ-012 SHALL have port outStall, output, 1, high while a send is held off because the FIFO is full.
REQ-013 SHALL have port outRxTotal, output, 16, count of words accepted since reset.

Function
REQ-014 SHALL implement a 2-state receive FSM: IDLE, ACK.
REQ-015 In IDLE, with send asserted and outCount<DEPTH at the edge: SHALL write inData, go to ACK, and drive outAck=2'b01 from the next cycle.
REQ-016 In IDLE, with send asserted and outCount==DEPTH: SHALL remain in IDLE, write nothing, and set outStall=1 in the next cycle.
REQ-017 outStall SHALL be registered; it SHALL clear the cycle after the stall condition ends.
REQ-018 In ACK: SHALL hold outAck=2'b01 while send stays asserted, and write no further words.
REQ-019 In ACK with send deasserted: SHALL return to IDLE with outAck=2'b00 the next cycle (4-phase handshake, one word per send pulse).
REQ-020 Send-to-ack latency SHALL be exactly 1 cycle when not full; drop-to-ack-release latency SHALL be exactly 1 cycle.
REQ-021 Full SHALL be evaluated on the occupancy at the start of the cycle; a pop in the same cycle SHALL NOT unblock a push.
REQ-022 The FIFO SHALL be first-word-fall-through: outValid=(outCount!=0) and outWord=mem[rdPtr], both derived from registers.
REQ-023 A pop SHALL occur at the edge when outValid and inReady are both 1; inReady while empty SHALL be ignored.
REQ-024 A simultaneous push and pop SHALL leave outCount unchanged and advance both pointers.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 outRxTotal SHALL increment by 1 per accepted word and wrap 16'hFFFF to 0.
REQ-027 outWord SHALL be 0 when the FIFO is empty.

Reset
REQ-028 With rstPER=1 at an edge: state=IDLE, outAck=2'b00, pointers=0, outCount=0, outValid=0, outStall=0, outRxTotal=0.
REQ-029 Reset during ACK or with the FIFO occupied SHALL discard all stored words; a send still asserted after reset SHALL be treated as a new request.
REQ-030 Reset SHALL take priority over push and pop in the same cycle.

Verification
REQ-031 Single word: after reset, inSend=01 with inData=16'h00A5 -> outAck=01 one cycle later; drop inSend -> outAck=00 one cycle later; outValid=1, outWord=16'h00A5, outCount=1, outRxTotal=1.
REQ-032 Fill to full: 4 handshakes carrying 1,2,3,4 with inReady=0, then a 5th send carrying 5 -> outStall=1, outAck stays 00, outCount=4; then pulse inReady for 1 cycle -> word 1 popped, then 5 accepted, outStall=0.
REQ-033 Order and wrap: 10 words 0..9 streamed with inReady=1 -> output order 0..9, no loss, outRxTotal=10, pointers wrapped.
REQ-034 Simultaneous push and pop at outCount=2 -> outCount stays 2, head advances by one word.
REQ-035 Reset mid-ACK with 3 words stored -> next cycle outAck=00, outCount=0, outValid=0, outRxTotal=0.
REQ-036 Non-01 inSend values (2'b10, 2'b11) in IDLE -> no write, outAck stays 00.

Source files
------------

// File: rtl/per_rx_buffer.sv
// ============================================================================
// per_rx_buffer
// ----------------------------------------------------------------------------
// Receive buffer between an upstream CPU and a downstream consumer. The CPU
// hands over one word per 4-phase send/ack handshake; words are queued in a
// small first-word-fall-through FIFO that the consumer drains with a
// valid/ready handshake.
//
// Ports
//   clkPER      in   1      clock, all state changes on the rising edge
//   rstPER      in   1      synchronous active-high reset
//   inSend      in   2      send request, asserted only when 2'b01
//   inData      in   WIDTH  upstream word, stable while inSend is asserted
//   outAck      out  2      acknowledge to upstream (2'b00 / 2'b01)
//   outValid    out  1      head-of-FIFO word is available
//   inReady     in   1      consumer takes the head word this cycle
//   outWord     out  WIDTH  head-of-FIFO word, 0 when empty
//   outCount    out  log2(DEPTH)+1  FIFO occupancy
//   outStall    out  1      a send is being held off because the FIFO is full
//   outRxTotal  out  16     words accepted since reset, wraps at 16'hFFFF
// ============================================================================
module per_rx_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4   // power of two, >= 2
) (
    input  logic                   clkPER,
    input  logic                   rstPER,
    input  logic [1:0]             inSend,
    input  logic [WIDTH-1:0]       inData,
    output logic [1:0]             outAck,
    output logic                   outValid,
    input  logic                   inReady,
    output logic [WIDTH-1:0]       outWord,
    output logic [$clog2(DEPTH):0] outCount,
    output logic                   outStall,
    output logic [15:0]            outRxTotal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } state_e;

    state_e             state_q;
    logic [1:0]         ack_q;
    logic               stall_q;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [15:0]        total_q,  total_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic send;
    logic full;
    logic push;
    logic pop;

    assign send = (inSend == 2'b01);
    // Full is judged on the occupancy at the start of the cycle, so a pop in
    // the same cycle never frees room for a push.
    assign full = (count_q == FULL_CNT);
    assign push = (state_q == ST_IDLE) && send && !full;
    assign pop  = (count_q != '0) && inReady;

    // ------------------------------------------------------------------------
    // Receive FSM: one word per send pulse, ack and stall registered.
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clkPER) begin
        if (rstPER) begin
            state_q <= ST_IDLE;
            ack_q   <= 2'b00;
            stall_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stall_q <= send && full;
                    if (send && !full) begin
                        state_q <= ST_ACK;
                        ack_q   <= 2'b01;
                    end
                end
                ST_ACK: begin
                    stall_q <= 1'b0;
                    if (!send) begin
                        state_q <= ST_IDLE;
                        ack_q   <= 2'b00;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 2'b00;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------------
    // NOTE: every next-state value gets a default first so no path through
    // the block leaves it unassigned and infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        total_d  = total_q;

        // Pointers wrap for free because DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            total_d  = total_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clkPER) begin
        if (rstPER) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            total_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            total_q  <= total_d;
        end
    end

    // NOTE: storage is not reset; occupancy is, and outWord is masked while
    // empty, so stale contents are never observable.
    always_ff @(posedge clkPER) begin
        if (!rstPER && push) begin
            mem_q[wr_ptr_q] <= inData;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, all derived from registers
    // ------------------------------------------------------------------------
    assign outAck     = ack_q;
    assign outStall   = stall_q;
    assign outCount   = count_q;
    assign outValid   = (count_q != '0);
    assign outWord    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign outRxTotal = total_q;

endmodule

// File: tb/tb_per_rx_buffer.sv
module tb_per_rx_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clkPER;
    logic             rstPER;
    logic [1:0]       inSend;
    logic [WIDTH-1:0] inData;
    logic [1:0]       outAck;
    logic             outValid;
    logic             inReady;
    logic [WIDTH-1:0] outWord;
    logic [2:0]       outCount;
    logic             outStall;
    logic [15:0]      outRxTotal;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp_w;

    per_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clkPER     (clkPER),
        .rstPER     (rstPER),
        .inSend     (inSend),
        .inData     (inData),
        .outAck     (outAck),
        .outValid   (outValid),
        .inReady    (inReady),
        .outWord    (outWord),
        .outCount   (outCount),
        .outStall   (outStall),
        .outRxTotal (outRxTotal)
    );

    initial clkPER = 1'b0;
    always #5 clkPER = ~clkPER;

    // Scoreboard consumer: a pop happens at the next rising edge whenever
    // valid and ready are both high outside reset.
    always @(negedge clkPER) begin
        if (rstPER === 1'b0 && outValid === 1'b1 && inReady === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got word %h, scoreboard empty", outWord);
            end else begin
                exp_w = exp_q.pop_front();
                if (outWord !== exp_w) begin
                    errors++;
                    $display("FAIL pop_order: got word %h, expected %h", outWord, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clkPER);
        #1;
    endtask

    task automatic apply_reset();
        rstPER  = 1'b1;
        inSend  = 2'b00;
        inData  = '0;
        inReady = 1'b0;
        tick();
        tick();
        rstPER  = 1'b0;
        exp_q.delete();
    endtask

    // Full 4-phase handshake for one word expected to be accepted at once.
    task automatic send_word(input logic [WIDTH-1:0] data);
        inSend = 2'b01;
        inData = data;
        exp_q.push_back(data);
        tick();
        checks++;
        if (outAck !== 2'b01) begin
            errors++;
            $display("FAIL ack_rise: data %h got outAck %b, expected 01", data, outAck);
        end
        inSend = 2'b00;
        tick();
        checks++;
        if (outAck !== 2'b00) begin
            errors++;
            $display("FAIL ack_fall: data %h got outAck %b, expected 00", data, outAck);
        end
    endtask

    task automatic drain();
        inReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (outValid === 1'b0) break;
        end
        inReady = 1'b0;
        checks++;
        if (outValid !== 1'b0 || outCount !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: outValid %b outCount %0d, expected 0/0", outValid, outCount);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_lost: %0d expected words never popped, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (outAck !== 2'b00 || outValid !== 1'b0 || outCount !== 3'd0 ||
            outStall !== 1'b0 || outRxTotal !== 16'd0 || outWord !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: ack %b valid %b count %0d stall %b total %0d word %h, expected 00 0 0 0 0 0000",
                     outAck, outValid, outCount, outStall, outRxTotal, outWord);
        end
    endtask

    task automatic test_single_word();
        apply_reset();
        inSend = 2'b01;
        inData = 16'h00A5;
        exp_q.push_back(16'h00A5);
        tick();
        checks++;
        if (outAck !== 2'b01 || outCount !== 3'd1) begin
            errors++;
            $display("FAIL single_ack: ack %b count %0d, expected 01 1", outAck, outCount);
        end
        tick();
        checks++;
        if (outAck !== 2'b01 || outCount !== 3'd1 || outRxTotal !== 16'd1) begin
            errors++;
            $display("FAIL single_hold: ack %b count %0d total %0d, expected 01 1 1", outAck, outCount, outRxTotal);
        end
        inSend = 2'b00;
        tick();
        checks++;
        if (outAck !== 2'b00 || outValid !== 1'b1 || outWord !== 16'h00A5 ||
            outCount !== 3'd1 || outRxTotal !== 16'd1) begin
            errors++;
            $display("FAIL single_done: ack %b valid %b word %h count %0d total %0d, expected 00 1 00a5 1 1",
                     outAck, outValid, outWord, outCount, outRxTotal);
        end
        drain();
    endtask

    task automatic test_fill_full();
        apply_reset();
        for (int i = 1; i <= 4; i++) send_word(WIDTH'(i));
        checks++;
        if (outCount !== 3'd4 || outWord !== 16'd1) begin
            errors++;
            $display("FAIL fill_count: count %0d head %h, expected 4 0001", outCount, outWord);
        end
        inSend = 2'b01;
        inData = 16'd5;
        exp_q.push_back(16'd5);
        tick();
        checks++;
        if (outStall !== 1'b1 || outAck !== 2'b00 || outCount !== 3'd4) begin
            errors++;
            $display("FAIL full_stall: stall %b ack %b count %0d, expected 1 00 4", outStall, outAck, outCount);
        end
        tick();
        checks++;
        if (outStall !== 1'b1 || outAck !== 2'b00 || outCount !== 3'd4) begin
            errors++;
            $display("FAIL full_hold: stall %b ack %b count %0d, expected 1 00 4", outStall, outAck, outCount);
        end
        // Pop in this cycle must not admit the push in the same cycle.
        inReady = 1'b1;
        tick();
        inReady = 1'b0;
        checks++;
        if (outCount !== 3'd3 || outStall !== 1'b1 || outAck !== 2'b00 || outWord !== 16'd2) begin
            errors++;
            $display("FAIL full_pop: count %0d stall %b ack %b head %h, expected 3 1 00 0002",
                     outCount, outStall, outAck, outWord);
        end
        tick();
        checks++;
        if (outCount !== 3'd4 || outStall !== 1'b0 || outAck !== 2'b01 || outRxTotal !== 16'd5) begin
            errors++;
            $display("FAIL full_accept: count %0d stall %b ack %b total %0d, expected 4 0 01 5",
                     outCount, outStall, outAck, outRxTotal);
        end
        inSend = 2'b00;
        tick();
        checks++;
        if (outAck !== 2'b00) begin
            errors++;
            $display("FAIL full_release: ack %b, expected 00", outAck);
        end
        drain();
    endtask

    task automatic test_order_wrap();
        apply_reset();
        inReady = 1'b1;
        for (int i = 0; i < 10; i++) send_word(WIDTH'(i));
        tick();
        inReady = 1'b0;
        checks++;
        if (outRxTotal !== 16'd10 || outCount !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_stream: total %0d count %0d pending %0d, expected 10 0 0",
                     outRxTotal, outCount, exp_q.size());
        end
        // Pointers now sit at 10 mod 4; a fresh word must still come out first.
        send_word(16'hBEEF);
        checks++;
        if (outWord !== 16'hBEEF || outCount !== 3'd1) begin
            errors++;
            $display("FAIL wrap_head: head %h count %0d, expected beef 1", outWord, outCount);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_word(16'd10);
        send_word(16'd11);
        inSend  = 2'b01;
        inData  = 16'd12;
        inReady = 1'b1;
        exp_q.push_back(16'd12);
        tick();
        inReady = 1'b0;
        checks++;
        if (outCount !== 3'd2 || outWord !== 16'd11 || outAck !== 2'b01) begin
            errors++;
            $display("FAIL push_pop: count %0d head %h ack %b, expected 2 000b 01", outCount, outWord, outAck);
        end
        inSend = 2'b00;
        tick();
        checks++;
        if (outRxTotal !== 16'd3) begin
            errors++;
            $display("FAIL push_pop_total: total %0d, expected 3", outRxTotal);
        end
        drain();
    endtask

    task automatic test_reset_mid_ack();
        apply_reset();
        send_word(16'h0101);
        send_word(16'h0202);
        inSend = 2'b01;
        inData = 16'h0303;
        tick();
        checks++;
        if (outAck !== 2'b01 || outCount !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset: ack %b count %0d, expected 01 3", outAck, outCount);
        end
        rstPER = 1'b1;
        tick();
        exp_q.delete();
        checks++;
        if (outAck !== 2'b00 || outCount !== 3'd0 || outValid !== 1'b0 ||
            outRxTotal !== 16'd0 || outStall !== 1'b0) begin
            errors++;
            $display("FAIL mid_ack_reset: ack %b count %0d valid %b total %0d stall %b, expected 00 0 0 0 0",
                     outAck, outCount, outValid, outRxTotal, outStall);
        end
        // Reset wins over a push that IDLE would otherwise accept.
        inData = 16'h0404;
        tick();
        checks++;
        if (outCount !== 3'd0 || outAck !== 2'b00) begin
            errors++;
            $display("FAIL reset_priority: count %0d ack %b, expected 0 00", outCount, outAck);
        end
        rstPER = 1'b0;
        exp_q.push_back(16'h0404);
        tick();
        checks++;
        if (outAck !== 2'b01 || outCount !== 3'd1 || outRxTotal !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_send: ack %b count %0d total %0d, expected 01 1 1", outAck, outCount, outRxTotal);
        end
        inSend = 2'b00;
        tick();
        drain();
    endtask

    task automatic test_bad_send();
        logic [1:0] codes [2];
        codes[0] = 2'b10;
        codes[1] = 2'b11;
        apply_reset();
        foreach (codes[i]) begin
            inSend = codes[i];
            inData = 16'hDEAD;
            tick();
            tick();
            checks++;
            if (outAck !== 2'b00 || outCount !== 3'd0 || outRxTotal !== 16'd0) begin
                errors++;
                $display("FAIL bad_send_%b: ack %b count %0d total %0d, expected 00 0 0",
                         codes[i], outAck, outCount, outRxTotal);
            end
        end
        inSend = 2'b00;
        tick();
    endtask

    initial begin
        rstPER  = 1'b1;
        inSend  = 2'b00;
        inData  = '0;
        inReady = 1'b0;
        test_reset();
        test_single_word();
        test_fill_full();
        test_order_wrap();
        test_back_to_back();
        test_reset_mid_ack();
        test_bad_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
